// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_ctrl_if: redirect, instruction-bus and decode handshake group |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface inst_fetch_ctrl_if;
  logic        eret;
  logic [31:0] epc;
  logic        exc_oc;
  logic        br_take;
  logic [31:0] br_target;

  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_allowin;

  modport master (
    input  eret, epc, exc_oc, br_take, br_target,
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output if_valid, if_pc, if_inst,
    input  id_allowin
  );

  modport slave (
    output eret, epc, exc_oc, br_take, br_target,
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  if_valid, if_pc, if_inst,
    output id_allowin
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_ctrl: fetch PC sequencer, single-outstanding instruction bus  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
  parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380
) (
  input wire                 clk,
  input wire                 resetn,
  inst_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        redir;
  logic [31:0] redir_tgt;

  assign redir     = bus.eret | bus.exc_oc | bus.br_take;
  assign redir_tgt = bus.eret ? bus.epc : (bus.exc_oc ? EXC_ADDR : bus.br_target);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir) fetch_pc_d = redir_tgt;
      end
      REQ: begin
        if (bus.inst_addr_ok) begin
          state_d = WAIT;
          // The accepted address is already stale: its response must be dropped.
          if (redir || pend_v_q) begin
            discard_d  = 1'b1;
            fetch_pc_d = redir ? redir_tgt : pend_pc_q;
            pend_v_d   = 1'b0;
          end
        end else if (redir) begin
          // inst_addr must stay put until accepted, so park the target.
          pend_v_d  = 1'b1;
          pend_pc_d = redir_tgt;
        end
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          if (discard_q || redir) begin
            discard_d = 1'b0;
            state_d   = REQ;
            if (redir) fetch_pc_d = redir_tgt;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = fetch_pc_q;
            if_inst_d  = bus.inst_rdata;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = HOLD;
          end
        end else if (redir) begin
          fetch_pc_d = redir_tgt;
          discard_d  = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          if_valid_d = 1'b0;
          fetch_pc_d = redir_tgt;
          state_d    = REQ;
        end else if (bus.id_allowin) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      discard_q  <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign bus.inst_req  = (state_q == REQ);
  assign bus.inst_wr   = 1'b0;
  assign bus.inst_size = 2'b10;
  assign bus.inst_addr = fetch_pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_ctrl: directed scenarios then random bus/redirect traffic  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_ADDR   = 32'hbfc0_0380;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .EXC_ADDR(EXC_ADDR)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural next PC plus a one-deep bus slave.
  logic [31:0] exp_pc;
  int          accepted;
  logic        out_v;
  logic [31:0] out_addr;
  int          out_lat;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.eret = 1'b0; bus.epc = 32'd0; bus.exc_oc = 1'b0;
    bus.br_take = 1'b0; bus.br_target = 32'd0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;
    bus.id_allowin = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},    {31'd0, bus.inst_req}, 32'd0);
    check({tag, "_addr"},   bus.inst_addr, RESET_ADDR);
    check({tag, "_valid"},  {31'd0, bus.if_valid}, 32'd0);
    check({tag, "_pc"},     bus.if_pc, 32'd0);
    check({tag, "_inst"},   bus.if_inst, 32'd0);
  endtask

  task automatic rand_cycle();
    int          r;
    logic        redir;
    logic [31:0] tgt;
    r = $urandom_range(0, 39);
    bus.eret      = (r == 0) || (r == 3);
    bus.exc_oc    = (r == 1) || (r == 3) || (r == 4);
    bus.br_take   = (r == 2) || (r == 3) || (r == 4);
    bus.epc       = $urandom;
    bus.br_target = $urandom;
    bus.inst_addr_ok = ($urandom_range(0, 3) != 0);
    bus.id_allowin   = ($urandom_range(0, 2) != 0);
    bus.inst_data_ok = out_v && (out_lat == 0);
    bus.inst_rdata   = bus.inst_data_ok ? mem_word(out_addr) : $urandom;

    check("r_wr", {31'd0, bus.inst_wr}, 32'd0);
    check("r_size", {30'd0, bus.inst_size}, 32'd2);
    if (prev_stall) begin
      check("r_req_hold", {31'd0, bus.inst_req}, 32'd1);
      check("r_addr_hold", bus.inst_addr, prev_addr);
    end
    if (prev_hold) begin
      check("r_valid_hold", {31'd0, bus.if_valid}, 32'd1);
      check("r_pc_hold", bus.if_pc, prev_pc);
      check("r_inst_hold", bus.if_inst, prev_inst);
    end

    redir = bus.eret | bus.exc_oc | bus.br_take;
    if (bus.eret)        tgt = bus.epc;
    else if (bus.exc_oc) tgt = EXC_ADDR;
    else                 tgt = bus.br_target;

    if (bus.if_valid && bus.id_allowin && !redir) begin
      check("r_if_pc", bus.if_pc, exp_pc);
      check("r_if_inst", bus.if_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    if (redir) exp_pc = tgt;

    prev_stall = bus.inst_req && !bus.inst_addr_ok;
    prev_addr  = bus.inst_addr;
    prev_hold  = bus.if_valid && !bus.id_allowin && !redir;
    prev_pc    = bus.if_pc;
    prev_inst  = bus.if_inst;

    if (bus.inst_data_ok) out_v = 1'b0;
    else if (out_v) out_lat--;
    if (bus.inst_req && bus.inst_addr_ok) begin
      out_v    = 1'b1;
      out_addr = bus.inst_addr;
      out_lat  = $urandom_range(0, 2);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    resetn = 1'b0;

    // Reset boot
    tick(); tick(); tick();
    check_reset_vals("rst");
    resetn = 1'b1;
    bus.id_allowin = 1'b1;
    bus.inst_addr_ok = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("boot_req", {31'd0, bus.inst_req}, 32'd1);
      check("boot_addr", bus.inst_addr, RESET_ADDR + 32'(4 * k));
      tick();
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = 32'h2408_0001;
      check("boot_wait_req", {31'd0, bus.inst_req}, 32'd0);
      tick();
      bus.inst_data_ok = 1'b0;
      check("boot_valid", {31'd0, bus.if_valid}, 32'd1);
      check("boot_if_pc", bus.if_pc, RESET_ADDR + 32'(4 * k));
      check("boot_if_inst", bus.if_inst, 32'h2408_0001);
      tick();
    end

    // Decode stall on the instruction at 0xbfc0000c
    tick();
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1234_5678;
    bus.id_allowin   = 1'b0;
    tick();
    bus.inst_data_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'd0, bus.if_valid}, 32'd1);
      check("stall_pc", bus.if_pc, 32'hbfc0_000c);
      check("stall_inst", bus.if_inst, 32'h1234_5678);
      check("stall_req", {31'd0, bus.inst_req}, 32'd0);
      tick();
    end
    bus.id_allowin = 1'b1;
    tick();
    check("stall_rel_req", {31'd0, bus.inst_req}, 32'd1);
    check("stall_rel_addr", bus.inst_addr, 32'hbfc0_0010);
    check("stall_rel_valid", {31'd0, bus.if_valid}, 32'd0);

    // Branch during WAIT
    tick();
    bus.br_take   = 1'b1;
    bus.br_target = 32'hbfc0_0100;
    tick();
    bus.br_take      = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hdead_beef;
    check("br_addr_n1", bus.inst_addr, 32'hbfc0_0100);
    tick();
    bus.inst_data_ok = 1'b0;
    check("br_valid", {31'd0, bus.if_valid}, 32'd0);
    check("br_req", {31'd0, bus.inst_req}, 32'd1);
    check("br_addr", bus.inst_addr, 32'hbfc0_0100);

    // Exception redirect while the request is not yet accepted
    for (int k = 1; k <= 4; k++) begin
      bus.exc_oc = (k == 2);
      tick();
      bus.exc_oc = 1'b0;
      check("exc_req_hold", {31'd0, bus.inst_req}, 32'd1);
      check("exc_addr_hold", bus.inst_addr, 32'hbfc0_0100);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hbad0_0001;
    tick();
    bus.inst_data_ok = 1'b0;
    check("exc_valid", {31'd0, bus.if_valid}, 32'd0);
    check("exc_req", {31'd0, bus.inst_req}, 32'd1);
    check("exc_addr", bus.inst_addr, EXC_ADDR);

    // Priority of simultaneous redirects in HOLD
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h0000_0042;
    bus.id_allowin   = 1'b0;
    tick();
    bus.inst_data_ok = 1'b0;
    check("pri_valid_pre", {31'd0, bus.if_valid}, 32'd1);
    check("pri_pc_pre", bus.if_pc, EXC_ADDR);
    bus.eret = 1'b1; bus.epc = 32'h8000_1000;
    bus.exc_oc = 1'b1; bus.br_take = 1'b1; bus.br_target = 32'hbfc0_0100;
    tick();
    bus.eret = 1'b0; bus.exc_oc = 1'b0; bus.br_take = 1'b0;
    bus.id_allowin = 1'b1;
    check("pri_valid", {31'd0, bus.if_valid}, 32'd0);
    check("pri_req", {31'd0, bus.inst_req}, 32'd1);
    check("pri_addr", bus.inst_addr, 32'h8000_1000);

    // Reset while WAIT with data arriving
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    resetn = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h7777_7777;
    tick();
    bus.inst_data_ok = 1'b0;
    check_reset_vals("rstw");
    tick();
    check("rstw_valid2", {31'd0, bus.if_valid}, 32'd0);
    resetn = 1'b1;
    tick();
    check("rstw_req", {31'd0, bus.inst_req}, 32'd1);
    check("rstw_addr", bus.inst_addr, RESET_ADDR);

    // Random traffic against the reference model
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn     = 1'b1;
    exp_pc     = RESET_ADDR;
    accepted   = 0;
    out_v      = 1'b0;
    out_addr   = 32'd0;
    out_lat    = 0;
    prev_stall = 1'b0;
    prev_addr  = 32'd0;
    prev_hold  = 1'b0;
    prev_pc    = 32'd0;
    prev_inst  = 32'd0;
    for (int c = 0; c < 3000; c++) rand_cycle();
    check("r_progress", {31'd0, (accepted >= 100)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer for the MIPS core. It owns the fetch PC, drives the SRAM-like instruction bus (one outstanding request), and hands fetched instructions to decode through a valid/allowin handshake. It applies redirects (eret, exception, taken branch) in priority order. A redirect that arrives while a request is in flight discards the stale response.

## Interface
- RESET_ADDR, 32'hbfc0_0000, fetch PC after reset
- EXC_ADDR, 32'hbfc0_0380, exception entry PC
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-low
- eret  in  1  eret redirect pulse, highest priority
- epc  in  32  eret target
- exc_oc  in  1  exception redirect pulse, to EXC_ADDR
- br_take  in  1  taken-branch redirect pulse, lowest priority
- br_target  in  32  branch target
- inst_req  out  1  bus request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  request address; stable while inst_req=1 and inst_addr_ok=0
- inst_addr_ok  in  1  address accepted this cycle (qualified by inst_req)
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- if_valid  out  1  instruction buffered for decode
- if_pc  out  32  PC of buffered instruction
- if_inst  out  32  buffered instruction
- id_allowin  in  1  decode accepts when if_valid=1

## Operation
- Registers:
  - state: IDLE, REQ, WAIT, HOLD.
  - fetch_pc.
  - discard: 1 bit.
  - pend_v/pend_pc: redirect captured during REQ.
  - Output buffer: if_valid/if_pc/if_inst.
- Redirect present when eret|exc_oc|br_take. Target = eret ? epc : exc_oc ? EXC_ADDR : br_target.
- br_take is asserted by decode only after the delay-slot instruction has been accepted. Any instruction in the output buffer at redirect time is wrong-path.
- inst_req = (state==REQ). inst_addr = fetch_pc.
- IDLE: go to REQ. A redirect in IDLE loads fetch_pc = target.
- REQ:
  - addr_ok=1: go to WAIT. If a redirect occurs this cycle or pend_v=1: set discard=1, fetch_pc = target (this-cycle redirect wins over pend_pc), clear pend_v.
  - addr_ok=0 with a redirect: pend_v=1, pend_pc=target (later redirect overwrites). fetch_pc and inst_addr are unchanged.
- WAIT:
  - Redirect: fetch_pc=target, discard=1.
  - data_ok with discard=0 and no redirect this cycle: load if_inst=inst_rdata, if_pc=fetch_pc, if_valid=1, fetch_pc+=4, go to HOLD.
  - data_ok with discard=1, or with a redirect this cycle: drop data, clear discard, go to REQ.
- HOLD:
  - Redirect: if_valid=0, fetch_pc=target, go to REQ.
  - Else if id_allowin: if_valid=0, go to REQ.
  - Else hold all outputs.
- Simultaneous redirect sources: only the highest priority applies; the others are ignored.
- PC arithmetic is 32-bit and wraps modulo 2^32. Alignment is not checked here.
- inst_data_ok outside WAIT is a protocol violation; ignored.

## Timing
- Reset values: state=IDLE, fetch_pc=RESET_ADDR, inst_req=0, inst_addr=RESET_ADDR, if_valid=0, if_pc=0, if_inst=0, discard=0, pend_v=0.
- resetn low at any edge, including mid-transaction, returns to the reset values. Any in-flight response is dropped because the bus is reset together with this block.
- First edge with resetn=1 moves to REQ: inst_req is high in the following cycle.
- Zero-wait bus (addr_ok in the request cycle, data_ok the next cycle), id_allowin=1:
  - req at cycle N, data_ok at N+1.
  - if_valid at N+2, next req at N+3.
  - Throughput: one instruction per 3 cycles.
- Redirect latency: a redirect in cycle N is reflected in inst_addr at N+1 unless REQ is holding an unaccepted address.
- if_valid never drops without id_allowin=1 or a redirect.

## Test plan
- Reset boot:
  - Stimulus: resetn low 3 cycles then high; addr_ok=1 always; data_ok one cycle after accept; rdata=0x2408_0001; allowin=1.
  - Required: inst_addr sequence 0xbfc0_0000, 0xbfc0_0004, 0xbfc0_0008; if_pc matches; if_inst=0x2408_0001.
- Decode stall:
  - Stimulus: id_allowin=0 for 5 cycles while in HOLD.
  - Required: if_valid, if_pc, if_inst stable; inst_req=0. On release, next inst_addr = if_pc+4.
- Branch during WAIT:
  - Stimulus: br_take with br_target=0xbfc0_0100 one cycle before data_ok.
  - Required: response dropped, if_valid stays 0; next inst_addr=0xbfc0_0100.
- Redirect during unaccepted REQ:
  - Stimulus: addr_ok held 0 for 4 cycles; exc_oc pulse in cycle 2.
  - Required: inst_addr holds the old value until accepted; that response is discarded; next inst_addr=0xbfc0_0380.
- Priority:
  - Stimulus: eret (epc=0x8000_1000), exc_oc and br_take all in the same cycle during HOLD.
  - Required: if_valid cleared next cycle; next inst_addr=0x8000_1000.
- Reset mid-WAIT:
  - Stimulus: resetn low while in WAIT with data_ok arriving.
  - Required: all outputs at reset values; no if_valid; after release, fetch restarts at 0xbfc0_0000.
